// File: rtl/control_niveles_cubos.sv
// Level sequencer for the falling-cubes game: timed play lapses that shrink per level,
// separated by fixed gaps, with pause, global abort and a completion pulse.
module control_niveles_cubos #(
  parameter int unsigned NUM_NIVELES  = 4,
  parameter int unsigned ANCHO        = 24,
  parameter int unsigned CICLOS_LAPSO = 1000000,
  parameter int unsigned REDUCCION    = 100000,
  parameter int unsigned CICLOS_ENTRE = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pausa,
  input  logic       finalizado_tiempo_juego,
  output logic       activar_timer,
  output logic       habilitar_cubos,
  output logic       intervalo,
  output logic       en_pausa,
  output logic [3:0] nivel,
  output logic       juego_terminado
);

  typedef enum logic [1:0] {INICIO, LAPSO, ENTRE, FIN} estado_t;

  localparam logic [ANCHO-1:0] FIN_ENTRE = ANCHO'(CICLOS_ENTRE - 1);
  localparam logic [3:0]       ULTIMO    = 4'(NUM_NIVELES - 1);

  estado_t          estado;
  logic [ANCHO-1:0] cnt;
  logic [ANCHO-1:0] fin_lapso_c;

  // Last count of the current level's lapse: LEN(nivel) - 1.
  assign fin_lapso_c = ANCHO'(CICLOS_LAPSO) - ANCHO'(nivel) * ANCHO'(REDUCCION) - ANCHO'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      estado        <= INICIO;
      cnt           <= '0;
      nivel         <= '0;
      activar_timer <= 1'b0;
    end else begin
      activar_timer <= 1'b0;
      case (estado)
        INICIO: begin
          if (start) begin
            estado        <= LAPSO;
            cnt           <= '0;
            nivel         <= '0;
            activar_timer <= 1'b1;
          end
        end
        LAPSO: begin
          if (finalizado_tiempo_juego) begin
            estado <= INICIO;
            cnt    <= '0;
            nivel  <= '0;
          end else if (!pausa) begin
            if (cnt == fin_lapso_c) begin
              estado <= (nivel == ULTIMO) ? FIN : ENTRE;
              cnt    <= '0;
            end else begin
              cnt <= cnt + ANCHO'(1);
            end
          end
        end
        ENTRE: begin
          if (finalizado_tiempo_juego) begin
            estado <= INICIO;
            cnt    <= '0;
            nivel  <= '0;
          end else if (!pausa) begin
            if (cnt == FIN_ENTRE) begin
              estado        <= LAPSO;
              cnt           <= '0;
              nivel         <= nivel + 4'd1;
              activar_timer <= 1'b1;
            end else begin
              cnt <= cnt + ANCHO'(1);
            end
          end
        end
        FIN: begin
          // Final level stays visible after a normal finish; an abort clears it.
          estado <= INICIO;
          cnt    <= '0;
          if (finalizado_tiempo_juego) nivel <= '0;
        end
        default: begin
          estado <= INICIO;
          cnt    <= '0;
          nivel  <= '0;
        end
      endcase
    end
  end

  assign habilitar_cubos = (estado == LAPSO) && !pausa;
  assign intervalo       = (estado == ENTRE);
  assign en_pausa        = ((estado == LAPSO) || (estado == ENTRE)) && pausa;
  assign juego_terminado = (estado == FIN);

endmodule

// File: tb/tb_control_niveles_cubos.sv
// Bench for control_niveles_cubos: progress-based reference model checked every cycle,
// directed scenario traces pinned against hand-computed cycle masks, then random stimulus.
module tb_control_niveles_cubos;

  localparam int unsigned NN = 3;
  localparam int unsigned AN = 8;
  localparam int unsigned CL = 10;
  localparam int unsigned RD = 2;
  localparam int unsigned CE = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       pausa = 1'b0;
  logic       finalizado_tiempo_juego = 1'b0;
  logic       activar_timer, habilitar_cubos, intervalo, en_pausa, juego_terminado;
  logic [3:0] nivel;

  control_niveles_cubos #(
    .NUM_NIVELES(NN), .ANCHO(AN), .CICLOS_LAPSO(CL), .REDUCCION(RD), .CICLOS_ENTRE(CE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pausa(pausa),
    .finalizado_tiempo_juego(finalizado_tiempo_juego),
    .activar_timer(activar_timer), .habilitar_cubos(habilitar_cubos),
    .intervalo(intervalo), .en_pausa(en_pausa), .nivel(nivel),
    .juego_terminado(juego_terminado)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Game timeline as a flat list of segments: even = play lapse of level s/2, odd = gap.
  function automatic int seg_len(input int s);
    return (s % 2 == 0) ? int'(CL) - (s / 2) * int'(RD) : int'(CE);
  endfunction

  function automatic int total_len();
    int t = 0;
    for (int s = 0; s < 2 * int'(NN) - 1; s++) t += seg_len(s);
    return t;
  endfunction

  function automatic int seg_of(input int p);
    int acc = 0;
    for (int s = 0; s < 2 * int'(NN) - 1; s++) begin
      acc += seg_len(s);
      if (p < acc) return s;
    end
    return 2 * int'(NN) - 2;
  endfunction

  function automatic bit lapso_begins_at(input int p);
    int acc = 0;
    for (int s = 0; s < 2 * int'(NN) - 1; s++) begin
      if (s % 2 == 0 && p == acc) return 1'b1;
      acc += seg_len(s);
    end
    return 1'b0;
  endfunction

  // Model: idle / playing with unpaused progress m_p / finished for one cycle.
  int         m_fase  = 0;
  int         m_p     = 0;
  logic [3:0] m_niv   = '0;
  logic       m_pulse = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_fase = 0; m_p = 0; m_niv = '0; m_pulse = 1'b0;
    end else if (m_fase == 0) begin
      m_pulse = 1'b0;
      if (start) begin m_fase = 1; m_p = 0; m_niv = '0; m_pulse = 1'b1; end
    end else if (m_fase == 1) begin
      m_pulse = 1'b0;
      if (finalizado_tiempo_juego) begin
        m_fase = 0; m_niv = '0;
      end else if (!pausa) begin
        m_p++;
        if (m_p == total_len()) begin
          m_fase = 2; m_niv = 4'(NN - 1);
        end else begin
          m_pulse = lapso_begins_at(m_p);
        end
      end
    end else begin
      m_fase = 0; m_pulse = 1'b0;
      if (finalizado_tiempo_juego) m_niv = '0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic       e_hab, e_int, e_enp, e_jt;
      logic [3:0] e_niv;
      int         s;
      e_hab = 1'b0; e_int = 1'b0; e_enp = 1'b0; e_jt = 1'b0; e_niv = m_niv;
      if (m_fase == 1) begin
        s     = seg_of(m_p);
        e_hab = (s % 2 == 0) && !pausa;
        e_int = (s % 2 == 1);
        e_enp = pausa;
        e_niv = 4'(s / 2);
      end else if (m_fase == 2) begin
        e_jt = 1'b1;
      end
      check("salidas {at,hab,int,enp,jt,nivel}",
            64'({activar_timer, habilitar_cubos, intervalo, en_pausa, juego_terminado, nivel}),
            64'({m_pulse, e_hab, e_int, e_enp, e_jt, e_niv}));
    end
  end

  // Per-scenario traces indexed by cycle number (cycle 0 = start-sampling cycle).
  int         cur = 0;
  logic [63:0] tr_at, tr_hab, tr_int, tr_enp, tr_jt;
  logic [3:0]  tr_niv [0:63];

  task automatic cycle(input logic s, input logic p, input logic a, input logic r);
    start = s; pausa = p; finalizado_tiempo_juego = a; reset = r;
    @(negedge clk);
    if (cur < 64) begin
      tr_at[cur]  = activar_timer;
      tr_hab[cur] = habilitar_cubos;
      tr_int[cur] = intervalo;
      tr_enp[cur] = en_pausa;
      tr_jt[cur]  = juego_terminado;
      tr_niv[cur] = nivel;
    end
    @(posedge clk); #1;
    cur++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_dut();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b0; pausa = 1'b0; finalizado_tiempo_juego = 1'b0; reset = 1'b0;
    cur = 0;
    tr_at = '0; tr_hab = '0; tr_int = '0; tr_enp = '0; tr_jt = '0;
    for (int i = 0; i < 64; i++) tr_niv[i] = '0;
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  initial begin
    @(posedge clk); #1;
    reset_dut();
    chk_on = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset salidas",
          64'({activar_timer, habilitar_cubos, intervalo, en_pausa, juego_terminado, nivel}), 64'd0);
    @(posedge clk); #1;

    // Full game
    reset_dut();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(33);
    check("full hab", tr_hab, rng(1, 10) | rng(14, 21) | rng(25, 30));
    check("full int", tr_int, rng(11, 13) | rng(22, 24));
    check("full at",  tr_at,  rng(1, 1) | rng(14, 14) | rng(25, 25));
    check("full jt",  tr_jt,  rng(31, 31));
    check("full niv15", 64'(tr_niv[15]), 64'd1);
    check("full niv26", 64'(tr_niv[26]), 64'd2);
    check("full niv32 held", 64'(tr_niv[32]), 64'd2);

    // Pause cycles 5-8
    reset_dut();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(28);
    check("pausa hab", tr_hab, rng(1, 4) | rng(9, 14) | rng(18, 25) | rng(29, 34));
    check("pausa enp", tr_enp, rng(5, 8));
    check("pausa int", tr_int, rng(15, 17) | rng(26, 28));
    check("pausa at",  tr_at,  rng(1, 1) | rng(18, 18) | rng(29, 29));
    check("pausa jt",  tr_jt,  rng(35, 35));

    // Abort in cycle 16, relaunch in cycle 20
    reset_dut();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(15);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("abort hab", tr_hab, rng(1, 10) | rng(14, 16) | rng(21, 22));
    check("abort at",  tr_at,  rng(1, 1) | rng(14, 14) | rng(21, 21));
    check("abort jt",  tr_jt,  64'd0);
    check("abort niv15", 64'(tr_niv[15]), 64'd1);
    check("abort niv17", 64'(tr_niv[17]), 64'd0);

    // Pause held across the level-0 terminal count
    reset_dut();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(9);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    check("pausa-tc hab", tr_hab, rng(1, 9) | rng(13, 13) | rng(17, 17));
    check("pausa-tc int", tr_int, rng(14, 16));
    check("pausa-tc at",  tr_at,  rng(1, 1) | rng(17, 17));

    // Start with abort in INICIO, then start pulse in LAPSO
    reset_dut();
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("start+abort hab", tr_hab, rng(1, 8));
    check("start en lapso at", tr_at, rng(1, 1));

    // Reset mid-gap at cycle 12
    reset_dut();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(11);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(8);
    check("reset-entre hab", tr_hab, rng(1, 10));
    check("reset-entre int", tr_int, rng(11, 12));
    check("reset-entre at",  tr_at,  rng(1, 1));
    check("reset-entre c13",
          64'({tr_at[13], tr_hab[13], tr_int[13], tr_enp[13], tr_jt[13], tr_niv[13]}), 64'd0);

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      cycle(1'(($urandom % 8) == 0), 1'(($urandom % 5) == 0),
            1'(($urandom % 64) == 0), 1'(($urandom % 256) == 0));
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
